// File: rtl/bitty_pkg.sv
// Shared types and instruction field offsets for the parametrised bitty core.
package bitty_pkg;

  typedef enum logic [1:0] {IDLE, LOAD, EXEC, WB} state_t;

  typedef enum logic [2:0] {
    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SHL, OP_SHR, OP_CMP
  } alu_op_t;

  typedef enum logic [1:0] {FMT_REG, FMT_IMM, FMT_NOP, FMT_ILL} fmt_t;

  localparam int FMT_LSB = 0;
  localparam int OP_LSB  = 2;
  localparam int IMM_LSB = 5;

endpackage

// File: rtl/bitty_alu_p.sv
// Combinational ALU: unsigned arithmetic/logic, shifts and three-way compare.
module bitty_alu_p
  import bitty_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  alu_op_t           op,
  output logic [DATA_W-1:0] result,
  output logic              carry,
  output logic              zero
);

  localparam int SH_W = $clog2(DATA_W);

  logic [DATA_W:0]   sum;
  logic [SH_W-1:0]   shamt;

  assign sum   = {1'b0, a} + {1'b0, b};
  assign shamt = b[SH_W-1:0];

  always_comb begin
    result = '0;
    carry  = 1'b0;
    case (op)
      OP_ADD: begin
        result = sum[DATA_W-1:0];
        carry  = sum[DATA_W];
      end
      OP_SUB: begin
        result = a - b;
        carry  = (a < b);
      end
      OP_AND: result = a & b;
      OP_OR:  result = a | b;
      OP_XOR: result = a ^ b;
      OP_SHL: result = a << shamt;
      OP_SHR: result = a >> shamt;
      OP_CMP: begin
        if (a == b)     result = '0;
        else if (a > b) result = DATA_W'(1);
        else            result = DATA_W'(2);
      end
      default: result = '0;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/bitty_core_p.sv
// Parametrised bitty core: register file, instruction register and a
// four-state latch/load/execute/writeback sequencer around bitty_alu_p.
module bitty_core_p
  import bitty_pkg::*;
#(
  parameter int              DATA_W    = 16,
  parameter int              NUM_REGS  = 8,
  parameter int              REG_AW    = $clog2(NUM_REGS),
  parameter int              INSTR_W   = 2*REG_AW + 10,
  parameter int              IMM_W     = INSTR_W - REG_AW - 5,
  parameter logic [DATA_W-1:0] RESET_VAL = DATA_W'(10)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               run,
  input  logic [INSTR_W-1:0] d_instr,
  input  logic [REG_AW-1:0]  dbg_sel,
  output logic [DATA_W-1:0]  d_out,
  output logic               done,
  output logic               busy,
  output logic               flag_c,
  output logic               flag_z,
  output logic               illegal,
  output logic [DATA_W-1:0]  dbg_data
);

  logic [DATA_W-1:0]  regs [NUM_REGS];
  state_t             state;
  logic [INSTR_W-1:0] ir;
  logic [DATA_W-1:0]  s_reg;
  logic [DATA_W-1:0]  c_reg;

  logic [REG_AW-1:0]  rx;
  logic [REG_AW-1:0]  ry;
  alu_op_t            op;
  fmt_t               fmt;
  logic [IMM_W-1:0]   imm;
  logic [DATA_W-1:0]  b_opnd;
  logic               wr_en;

  logic [DATA_W-1:0]  alu_res;
  logic               alu_c;
  logic               alu_z;

  assign rx     = ir[INSTR_W-1 -: REG_AW];
  assign ry     = ir[INSTR_W-REG_AW-1 -: REG_AW];
  assign op     = alu_op_t'(ir[OP_LSB +: 3]);
  assign fmt    = fmt_t'(ir[FMT_LSB +: 2]);
  assign imm    = ir[IMM_LSB +: IMM_W];
  assign b_opnd = (fmt == FMT_IMM) ? DATA_W'(imm) : regs[ry];
  // NOP and ILL formats still walk EXEC/WB but must leave all state untouched
  assign wr_en  = (fmt == FMT_REG) || (fmt == FMT_IMM);

  bitty_alu_p #(.DATA_W(DATA_W)) u_alu (
    .a      (s_reg),
    .b      (b_opnd),
    .op     (op),
    .result (alu_res),
    .carry  (alu_c),
    .zero   (alu_z)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      ir     <= '0;
      s_reg  <= '0;
      c_reg  <= '0;
      flag_c <= 1'b0;
      flag_z <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= RESET_VAL;
    end else begin
      case (state)
        IDLE: if (run) begin
          ir    <= d_instr;
          state <= LOAD;
        end
        LOAD: begin
          s_reg <= regs[rx];
          state <= EXEC;
        end
        EXEC: begin
          if (wr_en) begin
            c_reg  <= alu_res;
            flag_c <= alu_c;
            flag_z <= alu_z;
          end
          state <= WB;
        end
        WB: begin
          if (wr_en) regs[rx] <= c_reg;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign d_out    = c_reg;
  assign done     = (state == WB);
  assign busy     = (state != IDLE);
  assign illegal  = done && (fmt == FMT_ILL);
  assign dbg_data = regs[dbg_sel];

endmodule

// File: tb/tb_bitty_core_p.sv
// Scoreboard bench for bitty_core_p: default config (a) and 8-bit/4-reg config (b).
module tb_bitty_core_p;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // DUT a: defaults
  logic        reset_a, run_a;
  logic [15:0] d_instr_a;
  logic [2:0]  dbg_sel_a;
  logic [15:0] d_out_a, dbg_data_a;
  logic        done_a, busy_a, flag_c_a, flag_z_a, illegal_a;

  // DUT b: DATA_W=8, NUM_REGS=4
  logic        reset_b, run_b;
  logic [13:0] d_instr_b;
  logic [1:0]  dbg_sel_b;
  logic [7:0]  d_out_b, dbg_data_b;
  logic        done_b, busy_b, flag_c_b, flag_z_b, illegal_b;

  bitty_core_p dut_a (
    .clk(clk), .reset(reset_a), .run(run_a), .d_instr(d_instr_a), .dbg_sel(dbg_sel_a),
    .d_out(d_out_a), .done(done_a), .busy(busy_a), .flag_c(flag_c_a), .flag_z(flag_z_a),
    .illegal(illegal_a), .dbg_data(dbg_data_a)
  );

  bitty_core_p #(.DATA_W(8), .NUM_REGS(4), .RESET_VAL(8'd10)) dut_b (
    .clk(clk), .reset(reset_b), .run(run_b), .d_instr(d_instr_b), .dbg_sel(dbg_sel_b),
    .d_out(d_out_b), .done(done_b), .busy(busy_b), .flag_c(flag_c_b), .flag_z(flag_z_b),
    .illegal(illegal_b), .dbg_data(dbg_data_b)
  );

  typedef struct {
    logic [15:0] d;
    logic        c;
    logic        z;
    logic        ill;
    logic [15:0] dbg;
    int          t;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitors: every done pulse must match the oldest expected entry.
  always @(negedge clk) begin
    exp_t e;
    if (done_a) begin
      if (qa.size() == 0) chk("a_unexpected_done", 16'd1, 16'd0);
      else begin
        e = qa.pop_front();
        chk("a_done_cycle", 16'(cyc), 16'(e.t));
        chk("a_d_out", d_out_a, e.d);
        chk("a_flag_c", {15'd0, flag_c_a}, {15'd0, e.c});
        chk("a_flag_z", {15'd0, flag_z_a}, {15'd0, e.z});
        chk("a_illegal", {15'd0, illegal_a}, {15'd0, e.ill});
        chk("a_dbg_old", dbg_data_a, e.dbg);
      end
    end
    if (done_b) begin
      if (qb.size() == 0) chk("b_unexpected_done", 16'd1, 16'd0);
      else begin
        e = qb.pop_front();
        chk("b_done_cycle", 16'(cyc), 16'(e.t));
        chk("b_d_out", {8'h0, d_out_b}, e.d);
        chk("b_flag_c", {15'd0, flag_c_b}, {15'd0, e.c});
        chk("b_flag_z", {15'd0, flag_z_b}, {15'd0, e.z});
        chk("b_illegal", {15'd0, illegal_b}, {15'd0, e.ill});
        chk("b_dbg_old", {8'h0, dbg_data_b}, e.dbg);
      end
    end
  end

  task automatic wait_idle(input bit b);
    for (int i = 0; i < 10 && (b ? busy_b : busy_a); i++) @(negedge clk);
    chk(b ? "b_idle_timeout" : "a_idle_timeout", {15'd0, (b ? busy_b : busy_a)}, 16'd0);
  endtask

  task automatic drive(input bit b, input logic [15:0] instr, input int sel, input logic r);
    if (b) begin d_instr_b = instr[13:0]; dbg_sel_b = sel[1:0]; run_b = r; end
    else   begin d_instr_a = instr;       dbg_sel_a = sel[2:0]; run_a = r; end
  endtask

  task automatic issue(input bit b, input logic [15:0] instr, input int sel,
                       input logic [15:0] d, input logic c, input logic z,
                       input logic ill, input logic [15:0] dbg);
    exp_t e;
    @(negedge clk);
    drive(b, instr, sel, 1'b1);
    @(posedge clk); #1;
    e = '{d: d, c: c, z: z, ill: ill, dbg: dbg, t: cyc + 2};
    if (b) qb.push_back(e); else qa.push_back(e);
    @(negedge clk);
    drive(b, ~instr, sel, 1'b0);
    chk(b ? "b_busy" : "a_busy", {15'd0, (b ? busy_b : busy_a)}, 16'd1);
    wait_idle(b);
  endtask

  task automatic check_reg(input bit b, input int sel, input logic [15:0] v);
    if (b) dbg_sel_b = sel[1:0]; else dbg_sel_a = sel[2:0];
    #1;
    chk($sformatf("%s_reg%0d", b ? "b" : "a", sel), b ? {8'h0, dbg_data_b} : dbg_data_a, v);
  endtask

  initial begin
    exp_t e;
    reset_a = 1'b1; reset_b = 1'b1; run_a = 1'b0; run_b = 1'b0;
    d_instr_a = '0; d_instr_b = '0; dbg_sel_a = '0; dbg_sel_b = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_a = 1'b0; reset_b = 1'b0;

    for (int i = 0; i < 8; i++) check_reg(1'b0, i, 16'h000A);
    for (int i = 0; i < 4; i++) check_reg(1'b1, i, 16'h000A);
    chk("a_rst_d_out", d_out_a, 16'h0);
    chk("a_rst_ctl", {11'd0, done_a, busy_a, flag_c_a, flag_z_a, illegal_a}, 16'h0);

    // R1 += R2
    issue(1'b0, 16'h2800, 1, 16'h0014, 1'b0, 1'b0, 1'b0, 16'h000A);
    check_reg(1'b0, 1, 16'h0014);

    // run held high: R4 ^= R4 then R4 |= 0x35, accepted 4 cycles apart
    @(negedge clk);
    drive(1'b0, 16'h9010, 4, 1'b1);
    @(posedge clk); #1;
    e = '{d: 16'h0000, c: 1'b0, z: 1'b1, ill: 1'b0, dbg: 16'h000A, t: cyc + 2};
    qa.push_back(e);
    e = '{d: 16'h0035, c: 1'b0, z: 1'b0, ill: 1'b0, dbg: 16'h0000, t: cyc + 6};
    qa.push_back(e);
    @(negedge clk);
    drive(1'b0, 16'h86AD, 4, 1'b1);
    repeat (4) @(negedge clk);
    drive(1'b0, 16'h0000, 4, 1'b0);
    wait_idle(1'b0);
    check_reg(1'b0, 4, 16'h0035);

    // reset during EXEC aborts the instruction
    @(negedge clk);
    drive(1'b0, 16'h2800, 1, 1'b1);
    @(negedge clk);
    run_a = 1'b0;
    @(negedge clk);
    reset_a = 1'b1;
    @(negedge clk);
    reset_a = 1'b0;
    chk("a_abort_busy", {15'd0, busy_a}, 16'd0);
    chk("a_abort_d_out", d_out_a, 16'h0);
    repeat (3) @(negedge clk);
    for (int i = 0; i < 8; i++) check_reg(1'b0, i, 16'h000A);

    // R3 -= imm 0xFF
    issue(1'b0, 16'h7FE5, 3, 16'hFF0B, 1'b1, 1'b0, 1'b0, 16'h000A);
    check_reg(1'b0, 3, 16'hFF0B);

    // fmt 10 and 11: nothing written, C and flags held
    issue(1'b0, 16'h2802, 1, 16'hFF0B, 1'b1, 1'b0, 1'b0, 16'h000A);
    issue(1'b0, 16'h2803, 1, 16'hFF0B, 1'b1, 1'b0, 1'b1, 16'h000A);
    chk("a_illegal_after", {15'd0, illegal_a}, 16'd0);
    check_reg(1'b0, 1, 16'h000A);
    check_reg(1'b0, 3, 16'hFF0B);

    // 8-bit / 4-register configuration
    issue(1'b1, 16'h0135, 0, 16'h0014, 1'b0, 1'b0, 1'b0, 16'h000A);
    issue(1'b1, 16'h1165, 1, 16'h00FF, 1'b1, 1'b0, 1'b0, 16'h000A);
    issue(1'b1, 16'h1021, 1, 16'h0000, 1'b1, 1'b1, 1'b0, 16'h00FF);
    issue(1'b1, 16'h201C, 2, 16'h0002, 1'b0, 1'b0, 1'b0, 16'h000A);
    check_reg(1'b1, 0, 16'h0014);
    check_reg(1'b1, 1, 16'h0000);
    check_reg(1'b1, 2, 16'h0002);

    repeat (3) @(negedge clk);
    chk("a_queue_empty", 16'(qa.size()), 16'd0);
    chk("b_queue_empty", 16'(qb.size()), 16'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
